simon_game_ctrl: RTL

SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

---
 rtl/simon_pkg.sv | 25 ++
 rtl/simon_lfsr.sv | 17 +
 rtl/simon_game_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared state encoding and LFSR constants for the Simon game controller.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        CHECK,
        WIN,
        LOSE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of the polynomial map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies the random colour for each new element.
module simon_lfsr (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    import simon_pkg::*;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon memory game: grows a random sequence, replays it on the LEDs and checks the player's entries.
//   state    | meaning
//   IDLE     | waiting for start after reset
//   ADD      | append one random element, bump level
//   SHOW_ON  | light seq[show_idx] for SHOW_TICKS
//   SHOW_OFF | dark gap for GAP_TICKS
//   WAIT_IN  | input enabled, timeout running
//   CHECK    | compare captured entry with seq[in_idx]
//   WIN      | full sequence repeated, held until start
//   LOSE     | wrong entry or timeout, held until start
module simon_game_ctrl #(
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 25_000_000,
    parameter int GAP_TICKS     = 12_500_000,
    parameter int TIMEOUT_TICKS = 250_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       entry_valid,
    input  logic [3:0] entry_val,
    output logic       input_en,
    output logic [9:0] led,
    output logic [5:0] level,
    output logic       win,
    output logic       game_over
);
    import simon_pkg::*;

    localparam int CW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] SHOW_LOAD = CW'(SHOW_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_TICKS - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [LW-1:0] lvl, show_idx, in_idx;
    logic [3:0]    entry_q;
    logic [3:0]    seq [2**LW];
    logic [15:0]   lfsr_q;
    logic          lfsr_unused;
    logic          clr_level, add_elem, inc_show, clr_in, inc_in, cap_entry;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Only the low two bits pick the colour.
    assign lfsr_unused = ^lfsr_q[15:2];
    assign level       = 6'(lvl);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_level  = 1'b0;
        add_elem   = 1'b0;
        inc_show   = 1'b0;
        clr_in     = 1'b0;
        inc_in     = 1'b0;
        cap_entry  = 1'b0;
        led        = '0;
        input_en   = 1'b0;
        win        = 1'b0;
        game_over  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_level  = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                add_elem   = 1'b1;
                cnt_next   = SHOW_LOAD;
                state_next = SHOW_ON;
            end
            SHOW_ON: begin
                led = {6'b0, seq[show_idx]};
                if (cnt == '0) begin
                    cnt_next   = GAP_LOAD;
                    state_next = SHOW_OFF;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            SHOW_OFF: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else if (show_idx < lvl - LW'(1)) begin
                    inc_show   = 1'b1;
                    cnt_next   = SHOW_LOAD;
                    state_next = SHOW_ON;
                end else begin
                    clr_in     = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    state_next = WAIT_IN;
                end
            end
            WAIT_IN: begin
                input_en = 1'b1;
                // An entry on the expiry cycle still counts.
                if (entry_valid) begin
                    led        = {6'b0, entry_val};
                    cap_entry  = 1'b1;
                    state_next = CHECK;
                end else if (cnt == '0) begin
                    state_next = LOSE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            CHECK: begin
                if (entry_q != seq[in_idx]) begin
                    state_next = LOSE;
                end else if (in_idx < lvl - LW'(1)) begin
                    inc_in     = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    state_next = WAIT_IN;
                end else if (lvl == LW'(MAX_LEN)) begin
                    state_next = WIN;
                end else begin
                    state_next = ADD;
                end
            end
            WIN: begin
                win = 1'b1;
                led = 10'h2AA;
                if (start) begin
                    clr_level  = 1'b1;
                    state_next = ADD;
                end
            end
            LOSE: begin
                game_over = 1'b1;
                led       = 10'h3FF;
                if (start) begin
                    clr_level  = 1'b1;
                    state_next = ADD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            lvl      <= '0;
            show_idx <= '0;
            in_idx   <= '0;
            entry_q  <= '0;
        end else begin
            cnt <= cnt_next;
            if (clr_level) begin
                lvl <= '0;
            end else if (add_elem) begin
                lvl <= lvl + LW'(1);
            end
            if (add_elem) begin
                show_idx <= '0;
            end else if (inc_show) begin
                show_idx <= show_idx + LW'(1);
            end
            if (clr_in) begin
                in_idx <= '0;
            end else if (inc_in) begin
                in_idx <= in_idx + LW'(1);
            end
            if (cap_entry) begin
                entry_q <= entry_val;
            end
        end
    end

    // Sequence memory is deliberately not reset; level bounds what is ever read.
    always_ff @(posedge clk) begin
        if (add_elem) begin
            seq[lvl] <= 4'b0001 << lfsr_q[1:0];
        end
    end

endmodule
